// File: rtl/calc_ctrl_fsm.sv
// Calculator control FSM: assembles BCD operands from key strobes, hands them to a
// multi-cycle BCD ALU via a start/done handshake and selects what the display shows.
module calc_ctrl_fsm #(
    parameter int         DIGITS  = 4,
    parameter logic [3:0] ERR_NIB = 4'hE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic [4*DIGITS-1:0]   alu_res,
    input  logic                  alu_done,
    input  logic                  alu_err,
    output logic [4*DIGITS-1:0]   alu_num1,
    output logic [4*DIGITS-1:0]   alu_num2,
    output logic [3:0]            alu_op,
    output logic                  alu_start,
    output logic [4*DIGITS-1:0]   display,
    output logic                  err,
    output logic [2:0]            state
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIGITS);
    localparam logic [W-1:0]  NUM_ZERO = {W{1'b0}};

    typedef enum logic [2:0] {
        ST_ENTRY1 = 3'd0,
        ST_ENTRY2 = 3'd1,
        ST_CALC   = 3'd2,
        ST_SHOW   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [W-1:0]    r_num1,    w_num1_nxt;
    logic [W-1:0]    r_num2,    w_num2_nxt;
    logic [W-1:0]    r_result,  w_result_nxt;
    logic [CW-1:0]   r_cnt1,    w_cnt1_nxt;
    logic [CW-1:0]   r_cnt2,    w_cnt2_nxt;
    logic [3:0]      r_op,      w_op_nxt;
    logic [3:0]      r_pend_op, w_pend_op_nxt;
    logic            r_chain,   w_chain_nxt;
    logic [W-1:0]    r_display, w_display_nxt;
    logic            r_err;
    logic            r_start;
    logic            w_full_clr;
    logic            w_is_digit;
    logic            w_is_eq;
    logic            w_is_ac;
    logic            w_is_op;

    // A digit is accepted while there is room and it would not become a leading zero.
    function automatic logic digit_ok(input logic [W-1:0] num, input logic [CW-1:0] cnt,
                                      input logic [3:0] key);
        return (cnt < CNT_MAX) && !((key == 4'd0) && (num == NUM_ZERO));
    endfunction

    assign w_is_digit = key_valid && (key_code <= 4'd9);
    assign w_is_eq    = key_valid && (key_code == 4'd10);
    assign w_is_ac    = key_valid && (key_code == 4'd11);
    assign w_is_op    = key_valid && (key_code >= 4'd12);

    assign alu_num1  = r_num1;
    assign alu_num2  = r_num2;
    assign alu_op    = r_op;
    assign alu_start = r_start;
    assign display   = r_display;
    assign err       = r_err;
    assign state     = r_state;

    // Next-state and operand update for the key / ALU event of this cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_num1_nxt    = r_num1;
        w_num2_nxt    = r_num2;
        w_result_nxt  = r_result;
        w_cnt1_nxt    = r_cnt1;
        w_cnt2_nxt    = r_cnt2;
        w_op_nxt      = r_op;
        w_pend_op_nxt = r_pend_op;
        w_chain_nxt   = r_chain;
        w_full_clr    = 1'b0;
        case (r_state)
            ST_ENTRY1: begin
                if (w_is_digit) begin
                    if (digit_ok(r_num1, r_cnt1, key_code)) begin
                        w_num1_nxt = {r_num1[W-5:0], key_code};
                        w_cnt1_nxt = r_cnt1 + CNT_ONE;
                    end else begin
                        w_num1_nxt = r_num1;
                    end
                end else if (w_is_op) begin
                    w_op_nxt    = key_code;
                    w_num2_nxt  = NUM_ZERO;
                    w_cnt2_nxt  = CNT_ZERO;
                    w_state_nxt = ST_ENTRY2;
                end else if (w_is_ac) begin
                    w_num1_nxt = NUM_ZERO;
                    w_cnt1_nxt = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_ENTRY1;
                end
            end
            ST_ENTRY2: begin
                if (w_is_digit) begin
                    if (digit_ok(r_num2, r_cnt2, key_code)) begin
                        w_num2_nxt = {r_num2[W-5:0], key_code};
                        w_cnt2_nxt = r_cnt2 + CNT_ONE;
                    end else begin
                        w_num2_nxt = r_num2;
                    end
                end else if (w_is_op) begin
                    if (r_cnt2 == CNT_ZERO) begin
                        w_op_nxt = key_code;
                    end else begin
                        w_pend_op_nxt = key_code;
                        w_chain_nxt   = 1'b1;
                        w_state_nxt   = ST_CALC;
                    end
                end else if (w_is_eq) begin
                    if (r_cnt2 != CNT_ZERO) begin
                        w_chain_nxt = 1'b0;
                        w_state_nxt = ST_CALC;
                    end else begin
                        w_state_nxt = ST_ENTRY2;
                    end
                end else if (w_is_ac) begin
                    if (r_cnt2 != CNT_ZERO) begin
                        w_num2_nxt = NUM_ZERO;
                        w_cnt2_nxt = CNT_ZERO;
                    end else begin
                        w_full_clr = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_ENTRY2;
                end
            end
            ST_CALC: begin
                if (alu_done) begin
                    if (alu_err) begin
                        w_state_nxt = ST_ERROR;
                    end else if (r_chain) begin
                        w_num1_nxt   = alu_res;
                        w_result_nxt = alu_res;
                        w_op_nxt     = r_pend_op;
                        w_num2_nxt   = NUM_ZERO;
                        w_cnt2_nxt   = CNT_ZERO;
                        w_state_nxt  = ST_ENTRY2;
                    end else begin
                        w_result_nxt = alu_res;
                        w_state_nxt  = ST_SHOW;
                    end
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_SHOW: begin
                if (w_is_digit) begin
                    w_num1_nxt  = {{(W-4){1'b0}}, key_code};
                    w_cnt1_nxt  = (key_code != 4'd0) ? CNT_ONE : CNT_ZERO;
                    w_num2_nxt  = NUM_ZERO;
                    w_cnt2_nxt  = CNT_ZERO;
                    w_state_nxt = ST_ENTRY1;
                end else if (w_is_op) begin
                    w_num1_nxt  = r_result;
                    w_op_nxt    = key_code;
                    w_num2_nxt  = NUM_ZERO;
                    w_cnt2_nxt  = CNT_ZERO;
                    w_state_nxt = ST_ENTRY2;
                end else if (w_is_eq) begin
                    // Repeat-equals: previous result becomes operand 1, operand 2 and op kept.
                    w_num1_nxt  = r_result;
                    w_state_nxt = ST_CALC;
                end else if (w_is_ac) begin
                    w_full_clr = 1'b1;
                end else begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_ERROR: begin
                if (w_is_ac) begin
                    w_full_clr = 1'b1;
                end else begin
                    w_state_nxt = ST_ERROR;
                end
            end
            default: begin
                w_full_clr = 1'b1;
            end
        endcase
        if (w_full_clr) begin
            w_state_nxt   = ST_ENTRY1;
            w_num1_nxt    = NUM_ZERO;
            w_num2_nxt    = NUM_ZERO;
            w_result_nxt  = NUM_ZERO;
            w_cnt1_nxt    = CNT_ZERO;
            w_cnt2_nxt    = CNT_ZERO;
            w_op_nxt      = 4'd0;
            w_pend_op_nxt = 4'd0;
            w_chain_nxt   = 1'b0;
        end else begin
            w_chain_nxt = w_chain_nxt;
        end
    end

    // Display follows the registered state, so it trails operand updates by one cycle.
    always_comb begin
        w_display_nxt = r_display;
        case (r_state)
            ST_ENTRY1: w_display_nxt = r_num1;
            ST_ENTRY2: w_display_nxt = (r_cnt2 != CNT_ZERO) ? r_num2 : r_num1;
            ST_CALC:   w_display_nxt = r_display;
            ST_SHOW:   w_display_nxt = r_result;
            ST_ERROR:  w_display_nxt = {DIGITS{ERR_NIB}};
            default:   w_display_nxt = r_display;
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_ENTRY1;
            r_num1    <= NUM_ZERO;
            r_num2    <= NUM_ZERO;
            r_result  <= NUM_ZERO;
            r_cnt1    <= CNT_ZERO;
            r_cnt2    <= CNT_ZERO;
            r_op      <= 4'd0;
            r_pend_op <= 4'd0;
            r_chain   <= 1'b0;
            r_display <= NUM_ZERO;
            r_err     <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_num1    <= w_num1_nxt;
            r_num2    <= w_num2_nxt;
            r_result  <= w_result_nxt;
            r_cnt1    <= w_cnt1_nxt;
            r_cnt2    <= w_cnt2_nxt;
            r_op      <= w_op_nxt;
            r_pend_op <= w_pend_op_nxt;
            r_chain   <= w_chain_nxt;
            r_display <= w_display_nxt;
            r_err     <= (w_state_nxt == ST_ERROR);
            r_start   <= (w_state_nxt == ST_CALC) && (r_state != ST_CALC);
        end
    end

endmodule
